// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master Wishbone classic arbiter with round-robin lock-per-cycle grant and bus watchdog
module wb_rr_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [1:0]  gnt_o
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_n;
  logic pref_m1, pref_m1_n;
  logic [CNT_W-1:0] cnt;
  logic g0, g1, stb, wd_err;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  // Next state looks only at cyc lines and the rr pointer, never at slave terminations
  always_comb begin
    state_n = state;
    pref_m1_n = pref_m1;
    if (state == IDLE)
      state_n = (m0_cyc_i && (!m1_cyc_i || !pref_m1)) ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
    else if (g0 && !m0_cyc_i) begin
      pref_m1_n = 1'b1;
      state_n = m1_cyc_i ? GNT1 : IDLE;
    end else if (g1 && !m1_cyc_i) begin
      pref_m1_n = 1'b0;
      state_n = m0_cyc_i ? GNT0 : IDLE;
    end
  end
  assign stb = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
  assign wd_err = stb && !wb_ack_i && !wb_err_i && cnt == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      pref_m1 <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      pref_m1 <= pref_m1_n;
      cnt <= (state_n != state || !stb || wb_ack_i || wb_err_i || wd_err) ? '0 : cnt + CNT_W'(1);
    end
  end
  assign gnt_o    = {g1, g0};
  assign wb_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign wb_stb_o = stb && !wd_err;
  assign wb_we_o  = g0 ? m0_we_i : g1 ? m1_we_i : 1'b0;
  assign wb_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : 4'b0;
  assign wb_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : 32'b0;
  assign wb_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : 32'b0;
  assign m0_ack_o = g0 && wb_ack_i;
  assign m0_err_o = g0 && (wb_err_i || wd_err);
  assign m0_dat_o = g0 ? wb_dat_i : 32'b0;
  assign m1_ack_o = g1 && wb_ack_i;
  assign m1_err_o = g1 && (wb_err_i || wd_err);
  assign m1_dat_o = g1 ? wb_dat_i : 32'b0;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: randomized scoreboard bench against a transaction-level arbiter model
module tb_wb_rr_arbiter;
  localparam int T = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn_i;
  logic mcyc[2], mstb[2], mwe[2];
  logic [3:0] msel[2];
  logic [31:0] madr[2], mdat[2];
  logic [31:0] m0_dat_o, m1_dat_o, wb_adr_o, wb_dat_o, wb_dat_i;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;
  logic [3:0] wb_sel_o;
  logic [1:0] gnt_o;
  wb_rr_arbiter #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_sel_i(msel[0]),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_sel_i(msel[1]),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .gnt_o(gnt_o)
  );
  typedef struct packed {
    logic [1:0]  gnt;
    logic [70:0] bus;
    logic [33:0] r0;
    logic [33:0] r1;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  // Monitor: samples mid low phase, well after the negedge stimulus settles
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", 71'(gnt_o), 71'(e.gnt));
        chk("slave_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, e.bus);
        chk("m0_resp", 71'({m0_ack_o, m0_err_o, m0_dat_o}), 71'(e.r0));
        chk("m1_resp", 71'({m1_ack_o, m1_err_o, m1_dat_o}), 71'(e.r1));
      end
    end
  end
  // Model: owner 0=none,1=m0,2=m1; last = master that most recently released (2 after reset -> m0 preferred)
  int owner, last, wcnt, nxt_rst;
  initial begin
    exp_t e;
    logic wd;
    logic [33:0] resp;
    int o, drop;
    owner = 0; last = 2; wcnt = 0; nxt_rst = 150;
    rstn_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 0; mstb[i] = 0; mwe[i] = 0; msel[i] = 0; madr[i] = 0; mdat[i] = 0;
    end
    wb_ack_i = 0; wb_err_i = 0; wb_dat_i = 0;
    for (int c = 0; c < 1200; c++) begin
      int ph;
      @(negedge clk);
      ph = c / 400;
      rstn_i = 1'b1;
      if (c < 2) rstn_i = 1'b0;
      else if (c >= nxt_rst && owner == 2) begin
        rstn_i = 1'b0;
        nxt_rst = c + 250;
      end
      drop = (ph == 0) ? 5 : 30;
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(drop) == 0) mcyc[i] = !mcyc[i];
        mstb[i] = mcyc[i] && (ph > 0 || $urandom_range(9) < 7);
        mwe[i] = 1'($urandom);
        msel[i] = 4'($urandom);
        madr[i] = $urandom;
        mdat[i] = $urandom;
      end
      wb_dat_i = $urandom;
      if (ph == 0) begin
        wb_ack_i = $urandom_range(3) == 0;
        wb_err_i = $urandom_range(15) == 0;
      end else if (ph == 1) begin
        wb_ack_i = 0;
        wb_err_i = 0;
      end else begin
        wb_ack_i = (wcnt == T - 1 && $urandom_range(1) == 1) || $urandom_range(39) == 0;
        wb_err_i = 0;
      end
      #1;
      e = '0;
      wd = 1'b0;
      o = owner - 1;
      if (rstn_i && owner != 0) begin
        wd = mstb[o] && !wb_ack_i && !wb_err_i && wcnt == T - 1;
        e.gnt = (o == 1) ? 2'b10 : 2'b01;
        e.bus = {mcyc[o], mstb[o] && !wd, mwe[o], msel[o], madr[o], mdat[o]};
        resp = {wb_ack_i, wb_err_i || wd, wb_dat_i};
        if (o == 1) e.r1 = resp;
        else e.r0 = resp;
      end
      q.push_back(e);
      if (!rstn_i) begin
        owner = 0; last = 2; wcnt = 0;
      end else if (owner == 0) begin
        if (mcyc[0] && mcyc[1]) owner = (last == 1) ? 2 : 1;
        else if (mcyc[0]) owner = 1;
        else if (mcyc[1]) owner = 2;
        wcnt = 0;
      end else if (!mcyc[o]) begin
        last = owner;
        owner = mcyc[1 - o] ? 2 - o : 0;
        wcnt = 0;
      end else
        wcnt = (mstb[o] && !wb_ack_i && !wb_err_i && !wd) ? wcnt + 1 : 0;
    end
    @(negedge clk);
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Two-master, one-slave Wishbone classic-cycle arbiter.
- Shares the single data-side Wishbone port between the instruction fetch unit (m0) and the load-store unit (m1).
- Registered round-robin grant is held for the whole bus cycle, i.e. while the owner's CYC stays high.
- Includes a bus-watchdog that terminates a stalled transfer with an error to the owning master.

Parameters:
- TIMEOUT, 16, max cycles a granted STB may wait for ACK/ERR before the arbiter issues ERR; legal range 2..255.
- CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- m0_cyc_i / m1_cyc_i  input  1  master cycle request.
- m0_stb_i / m1_stb_i  input  1  master strobe.
- m0_we_i / m1_we_i  input  1  master write enable.
- m0_sel_i / m1_sel_i  input  4  master byte select.
- m0_adr_i / m1_adr_i  input  32  master address.
- m0_dat_i / m1_dat_i  input  32  master write data.
- m0_dat_o / m1_dat_o  output  32  read data to master.
- m0_ack_o / m1_ack_o  output  1  ack to master.
- m0_err_o / m1_err_o  output  1  error to master (slave ERR or watchdog).
- wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  slave-side controls.
- wb_sel_o  output  4  slave byte select.
- wb_adr_o  output  32  slave address.
- wb_dat_o  output  32  slave write data.
- wb_dat_i  input  32  slave read data.
- wb_ack_i, wb_err_i  input  1 each  slave termination.
- gnt_o  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle.

Behaviour:
- Clock/reset: single clock clk; rstn_i asynchronous, active-low. Reset forces the FSM to IDLE, rr pointer to "m0 preferred", watchdog count to 0, and all outputs to 0.
- FSM states: IDLE, GNT0, GNT1. State is registered; gnt_o decodes the state directly.
- IDLE:
  - only m0_cyc_i high -> GNT0; only m1_cyc_i high -> GNT1.
  - both high -> grant the master the rr pointer prefers.
  - Arbitration latency is 1 cycle: the request is seen in cycle N and the slave sees CYC in cycle N+1.
- GNTx:
  - Slave outputs = master x inputs, combinational mux on state.
  - mx_ack_o = wb_ack_i; mx_err_o = wb_err_i | wd_err; mx_dat_o = wb_dat_i.
  - The other master's ack/err/dat outputs are forced to 0.
- Release: when the owner's cyc_i drops, the rr pointer switches to prefer the other master.
  - If the other master's cyc_i is high in that same cycle, go directly to its GNT state (no IDLE bubble).
  - Otherwise go to IDLE.
- Lock: grant never changes while the owner's cyc_i is high, even across multiple STB/ACK beats.
- IDLE outputs: wb_* outputs all 0, both masters' ack/err/dat outputs 0.
- Watchdog counter:
  - Counts each cycle in GNTx with wb_stb_o=1 and wb_ack_i=wb_err_i=0.
  - Clears on ack, err, stb low, or a state change.
  - When count == TIMEOUT-1 and still no termination, wd_err is asserted combinationally for exactly that cycle and wb_stb_o is forced to 0 that cycle; the counter then clears.
  - wd_err reaches only the owner; the owner keeps the grant until it drops cyc.
- Simultaneous wb_ack_i and wb_err_i: both are forwarded as-is (slave protocol violation; no filtering).
- ack arriving in the same cycle the watchdog fires: ack wins, no wd_err.
- A master dropping cyc mid-transfer (stb high, no ack) is legal. The grant is released and any late ack is dropped (no owner or wrong owner is never acked, because the mux follows the state).
- Reset asserted mid-transfer: all outputs return to 0 asynchronously; no ack is generated.
- RTL constraints: no combinational path from wb_ack_i to any cyc/grant decision; next-state logic uses only cyc_i signals and the rr pointer.

Test Plan:
- Reset, then m0_cyc/stb read @0x100 with ack after 2 cycles, wb_dat_i=0xDEADBEEF -> gnt_o=01 one cycle after request; m0_dat_o=0xDEADBEEF with m0_ack_o=1; m1_ack_o stays 0; back to IDLE after cyc drop.
- m0 and m1 both raise cyc in the same cycle after reset -> m0 granted first. When m0 drops cyc with m1 still pending, gnt_o goes 01->10 with no idle cycle. Repeating the simultaneous request later grants m1 first if m0 was last owner.
- m1 holds cyc across 3 write beats (sel=4'b0011, adr 0x200/0x204/0x208) while m0 requests -> m0 not granted until m1 drops cyc; wb_sel_o=0011 on every beat.
- Granted m0 strobes with no slave ack, TIMEOUT=16 -> m0_err_o pulses exactly in the 16th stb cycle with wb_stb_o=0 that cycle; counter restarts for the next stb.
- Slave asserts wb_ack_i in the same cycle the watchdog would fire -> m0_ack_o=1, m0_err_o=0.
- Assert rstn_i low while m1 is mid-transfer -> gnt_o=00, wb_cyc_o=0, m1_ack_o=0 immediately (asynchronously). After release, a simultaneous request grants m0 first.
